pterm_array: RTL and testbench

PTERM_ARRAY -- requirements
Module: pterm_array

---
 rtl/pterm_pkg.sv | 28 ++
 rtl/pterm_and.sv | 31 +++
 rtl/pterm_array.sv | 117 +++++++++++
 tb/tb_pterm_array.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pterm_pkg.sv
// Shared types and size helpers for the product-term array and its AND slices.
package pterm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ARMED = 2'd3
  } pterm_state_t;

  // Each UIM signal contributes a true and a complement column.
  function automatic int calc_ptw(input int nuim, input int nflb);
    return nflb + 2 * nuim;
  endfunction

  function automatic int calc_cfg_bits(input int nuim, input int nflb, input int npt);
    return npt * calc_ptw(nuim, nflb);
  endfunction

  function automatic int calc_nwords(input int cfg_bits, input int cw);
    return (cfg_bits + cw - 1) / cw;
  endfunction

  function automatic int calc_cntw(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/pterm_and.sv
// One product term: each input column is ORed with its config bit (1 = don't care),
// then all columns are ANDed.
module pterm_and
  import pterm_pkg::*;
#(
  parameter int NUIM = 40,
  parameter int NFLB = 16
) (
  input  logic [NUIM-1:0]                  uim,
  input  logic [NFLB-1:0]                  mc_flb,
  input  logic [calc_ptw(NUIM, NFLB)-1:0]  cfg,
  output logic                             term
);

  localparam int PTW = calc_ptw(NUIM, NFLB);

  logic [PTW-1:0] in_vec;

  assign in_vec[NFLB-1:0] = mc_flb;

  genvar gi;
  generate
    for (gi = 0; gi < NUIM; gi++) begin : g_uim
      assign in_vec[NFLB + 2*gi]     = uim[gi];
      assign in_vec[NFLB + 2*gi + 1] = ~uim[gi];
    end
  endgenerate

  assign term = &(in_vec | cfg);

endmodule

// File: rtl/pterm_array.sv
// Configurable product-term array: word-serial config load into a bit store,
// NPT combinational AND terms, and a registered product-term output.
module pterm_array
  import pterm_pkg::*;
#(
  parameter int NUIM = 40,
  parameter int NFLB = 16,
  parameter int NPT  = 5,
  parameter int CW   = 8
) (
  input  logic            gclk,
  input  logic            gclr,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic [CW-1:0]   cfg_data,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic [NUIM-1:0] uim,
  input  logic [NFLB-1:0] mc_flb,
  output logic [NPT-1:0]  pt
);

  localparam int PTW      = calc_ptw(NUIM, NFLB);
  localparam int CFG_BITS = calc_cfg_bits(NUIM, NFLB, NPT);
  localparam int NWORDS   = calc_nwords(CFG_BITS, CW);
  localparam int CNTW     = calc_cntw(NWORDS);
  localparam logic [CNTW-1:0] LAST_WORD = CNTW'(NWORDS - 1);

  pterm_state_t         state_reg, state_next;
  logic [CNTW-1:0]      wcnt_reg;
  logic [CFG_BITS-1:0]  cfg_reg, cfg_next;
  logic [NPT-1:0]       term;
  logic                 accept;
  logic                 erase;
  logic                 last_word;

  assign last_word = (wcnt_reg == LAST_WORD);

  // State register
  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; cfg_start always takes priority over a word in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (cfg_start) state_next = ST_ERASE;
      ST_ERASE: state_next = ST_LOAD;
      ST_LOAD: begin
        if (cfg_start)                 state_next = ST_ERASE;
        else if (accept && last_word)  state_next = ST_ARMED;
      end
      ST_ARMED: if (cfg_start) state_next = ST_ERASE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    erase     = 1'b0;
    case (state_reg)
      ST_ERASE: erase     = 1'b1;
      ST_LOAD:  cfg_ready = 1'b1;
      ST_ARMED: cfg_done  = 1'b1;
      default:  ;
    endcase
    accept = cfg_ready & cfg_valid & ~cfg_start;
  end

  // Word counter holds at the last index once armed, so it never wraps.
  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr)                        wcnt_reg <= '0;
    else if (cfg_start || erase)     wcnt_reg <= '0;
    else if (accept && !last_word)   wcnt_reg <= wcnt_reg + 1'b1;
  end

  // Each config bit knows its word and lane; lanes past CFG_BITS simply have no bit.
  genvar gi;
  generate
    for (gi = 0; gi < CFG_BITS; gi++) begin : g_cfg
      localparam int WORD = gi / CW;
      localparam int LANE = gi % CW;
      assign cfg_next[gi] = (accept && (wcnt_reg == CNTW'(WORD))) ? cfg_data[LANE] : cfg_reg[gi];
    end
  endgenerate

  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr)       cfg_reg <= '1;
    else if (erase) cfg_reg <= '1;
    else            cfg_reg <= cfg_next;
  end

  generate
    for (gi = 0; gi < NPT; gi++) begin : g_term
      pterm_and #(
        .NUIM (NUIM),
        .NFLB (NFLB)
      ) u_and (
        .uim    (uim),
        .mc_flb (mc_flb),
        .cfg    (cfg_reg[gi*PTW +: PTW]),
        .term   (term[gi])
      );
    end
  endgenerate

  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr)                       pt <= '0;
    else if (state_reg == ST_ARMED) pt <= term;
    else                            pt <= '0;
  end

endmodule

// File: tb/tb_pterm_array.sv
// Directed bench for pterm_array: default-size array plus a small parameter sweep.
module tb_pterm_array;

  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [7:0]  data;
  logic        ready, done;
  logic [39:0] uim;
  logic [15:0] flb;
  logic [4:0]  pt;

  logic        s_rst, s_start, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, s_done;
  logic [3:0]  s_uim;
  logic [1:0]  s_flb;
  logic [2:0]  s_pt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pterm_array dut (
    .gclk(clk), .gclr(rst), .cfg_start(start), .cfg_valid(valid), .cfg_data(data),
    .cfg_ready(ready), .cfg_done(done), .uim(uim), .mc_flb(flb), .pt(pt)
  );

  pterm_array #(.NUIM(4), .NFLB(2), .NPT(3), .CW(8)) dut_s (
    .gclk(clk), .gclr(s_rst), .cfg_start(s_start), .cfg_valid(s_valid), .cfg_data(s_data),
    .cfg_ready(s_ready), .cfg_done(s_done), .uim(s_uim), .mc_flb(s_flb), .pt(s_pt)
  );

  typedef struct {
    bit          phase;
    logic [39:0] uim;
    logic [15:0] flb;
    logic [4:0]  exp_pt;
  } vec_t;

  vec_t tbl [10];

  logic [479:0] cfg_ff, cfg_zero, cfg_a, cfg_b;
  logic [29:0]  s_cfg [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic big_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("erase_ready", {63'd0, ready}, 64'd0);
    tick();
  endtask

  task automatic big_words(input logic [479:0] cfg, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      valid = 1'b1;
      data  = cfg[k*8 +: 8];
      check("load_ready", {63'd0, ready}, 64'd1);
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic big_load(input logic [479:0] cfg, input string tag);
    big_start();
    big_words(cfg, 0, 60);
    check("load_done", {63'd0, done}, 64'd1);
    $display("load %s complete at %0t", tag, $time);
  endtask

  function automatic logic [2:0] ref_pt(input logic [29:0] c, input logic [3:0] u, input logic [1:0] f);
    logic [2:0] r;
    logic [9:0] inp;
    inp = {~u[3], u[3], ~u[2], u[2], ~u[1], u[1], ~u[0], u[0], f};
    for (int p = 0; p < 3; p++) r[p] = &(inp | c[p*10 +: 10]);
    return r;
  endfunction

  task automatic s_load(input logic [29:0] c, input logic [1:0] top2);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = (k < 3) ? c[k*8 +: 8] : {top2, c[29:24]};
      check("s_ready", {63'd0, s_ready}, 64'd1);
      check("s_done_early", {63'd0, s_done}, 64'd0);
      tick();
    end
    s_valid = 1'b0;
    check("s_done", {63'd0, s_done}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; uim = '0; flb = '0;
    s_rst = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_data = '0; s_uim = '0; s_flb = '0;

    cfg_ff   = '1;
    cfg_zero = '0;
    cfg_a    = '1; cfg_a[16] = 1'b0; cfg_a[19] = 1'b0;
    cfg_b    = '1; cfg_b[123] = 1'b0; cfg_b[195] = 1'b0; cfg_b[478] = 1'b0;
    s_cfg[0] = '1; s_cfg[0][2] = 1'b0; s_cfg[0][11] = 1'b0; s_cfg[0][29] = 1'b0;
    s_cfg[1] = '1; s_cfg[1][2] = 1'b0; s_cfg[1][3] = 1'b0; s_cfg[1][24] = 1'b0; s_cfg[1][26] = 1'b0;
    s_cfg[2] = 30'h2D7B_E6F3;

    tbl[0] = '{1'b0, 40'h00_0000_0000, 16'h0000, 5'h1E};
    tbl[1] = '{1'b0, 40'h00_0000_0001, 16'hFFFF, 5'h1F};
    tbl[2] = '{1'b0, 40'h00_0000_0003, 16'h0000, 5'h1E};
    tbl[3] = '{1'b0, 40'h00_0000_0002, 16'h1234, 5'h1E};
    tbl[4] = '{1'b0, 40'hFF_FFFF_FFFD, 16'h0000, 5'h1F};
    tbl[5] = '{1'b1, 40'h00_0000_0000, 16'h0000, 5'h0B};
    tbl[6] = '{1'b1, 40'h80_0000_0000, 16'h0008, 5'h1F};
    tbl[7] = '{1'b1, 40'h80_0000_0020, 16'h0008, 5'h1D};
    tbl[8] = '{1'b1, 40'hFF_FFFF_FFFF, 16'hFFFF, 5'h1D};
    tbl[9] = '{1'b1, 40'hFF_FFFF_FFDF, 16'hFFF7, 5'h1B};

    // Reset state
    #2;
    check("rst_pt", {59'd0, pt}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;
    valid = 1'b1; data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", {63'd0, ready}, 64'd0);
      check("idle_done", {63'd0, done}, 64'd0);
    end
    valid = 1'b0;

    // All-ones load: done after word 59, pt all ones one cycle later
    big_start();
    big_words(cfg_ff, 0, 59);
    check("done_early", {63'd0, done}, 64'd0);
    big_words(cfg_ff, 59, 1);
    check("done_rise", {63'd0, done}, 64'd1);
    check("armed_ready", {63'd0, ready}, 64'd0);
    check("pt_latency", {59'd0, pt}, 64'd0);
    uim = 40'h5A_C3F0_0F1E; flb = 16'h9C3A;
    tick();
    check("pt_allones", {59'd0, pt}, 64'h1F);
    $display("ff load: pt=%0h", pt);

    // Table-driven vectors for two configurations
    for (int ph = 0; ph < 2; ph++) begin
      big_load(ph == 0 ? cfg_a : cfg_b, ph == 0 ? "A" : "B");
      for (int i = 0; i < 10; i++) begin
        if (int'(tbl[i].phase) == ph) begin
          uim = tbl[i].uim; flb = tbl[i].flb;
          tick();
          check($sformatf("vec%0d_pt", i), {59'd0, pt}, {59'd0, tbl[i].exp_pt});
          $display("vec %0d uim=%0h flb=%0h pt=%0h", i, uim, flb, pt);
        end
      end
    end

    // Latency: output holds until the next edge after an input change
    big_load(cfg_a, "A2");
    uim = 40'h1; tick();
    check("lat_before", {59'd0, pt}, 64'h1F);
    uim = 40'h0; #1;
    check("lat_hold", {59'd0, pt}, 64'h1F);
    tick();
    check("lat_after", {59'd0, pt}, 64'h1E);

    // Abort after 30 words: fresh 60 words required
    big_start();
    big_words(cfg_zero, 0, 30);
    start = 1'b1; valid = 1'b1; data = 8'h00;
    tick();
    start = 1'b0; valid = 1'b0;
    check("abort_erase_ready", {63'd0, ready}, 64'd0);
    check("abort_erase_done", {63'd0, done}, 64'd0);
    tick();
    big_words(cfg_ff, 0, 59);
    check("abort_done_early", {63'd0, done}, 64'd0);
    big_words(cfg_ff, 59, 1);
    check("abort_done", {63'd0, done}, 64'd1);
    uim = 40'h0; tick();
    check("abort_pt", {59'd0, pt}, 64'h1F);
    $display("abort sequence: pt=%0h", pt);

    // cfg_start coinciding with the last word: start wins
    big_start();
    big_words(cfg_zero, 0, 59);
    start = 1'b1; valid = 1'b1; data = 8'h00;
    tick();
    start = 1'b0; valid = 1'b0;
    check("startwin_done", {63'd0, done}, 64'd0);
    check("startwin_ready", {63'd0, ready}, 64'd0);
    tick();
    big_words(cfg_ff, 0, 60);
    check("startwin_reload", {63'd0, done}, 64'd1);
    tick();
    check("startwin_pt", {59'd0, pt}, 64'h1F);

    // Random valid: only handshaken words count
    big_start();
    cnt = 0;
    for (int cyc = 0; cyc < 2000 && cnt < 60; cyc++) begin
      valid = 1'($urandom_range(0, 1));
      data  = cfg_b[cnt*8 +: 8];
      check("rand_ready", {63'd0, ready}, 64'd1);
      check("rand_done_early", {63'd0, done}, 64'd0);
      tick();
      if (valid) cnt++;
    end
    valid = 1'b0;
    check("rand_count", cnt, 64'd60);
    check("rand_done", {63'd0, done}, 64'd1);
    valid = 1'b1; data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("extra_ready", {63'd0, ready}, 64'd0);
      check("extra_done", {63'd0, done}, 64'd1);
    end
    valid = 1'b0;
    uim = 40'h0; flb = 16'h0;
    tick();
    check("rand_pt", {59'd0, pt}, 64'h0B);
    $display("random-valid load: accepted=%0d pt=%0h", cnt, pt);

    // Async clear while armed
    #2 rst = 1'b1;
    #1;
    check("clr_pt", {59'd0, pt}, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    check("clr_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    tick();
    check("clr_idle_ready", {63'd0, ready}, 64'd0);

    // Async clear during word 45
    big_start();
    big_words(cfg_zero, 0, 45);
    valid = 1'b1; data = 8'h00;
    #2 rst = 1'b1;
    #1;
    check("mid_clr_ready", {63'd0, ready}, 64'd0);
    check("mid_clr_done", {63'd0, done}, 64'd0);
    check("mid_clr_pt", {59'd0, pt}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_clr_ready", {63'd0, ready}, 64'd0);
      check("post_clr_done", {63'd0, done}, 64'd0);
    end
    valid = 1'b0;
    big_load(cfg_a, "A3");
    uim = 40'h0; tick();
    check("post_clr_pt", {59'd0, pt}, 64'h1E);

    // Small-parameter sweep against the reference model
    s_load(s_cfg[0], 2'b11);
    s_uim = 4'b0001; s_flb = 2'b10; tick();
    check("s_hand0", {61'd0, s_pt}, 64'h7);
    s_uim = 4'b1000; s_flb = 2'b00; tick();
    check("s_hand1", {61'd0, s_pt}, 64'h0);
    for (int ci = 0; ci < 3; ci++) begin
      if (ci > 0) s_load(s_cfg[ci], (ci == 1) ? 2'b00 : 2'b11);
      for (int v = 0; v < 64; v++) begin
        s_uim = 4'(v >> 2); s_flb = 2'(v);
        tick();
        check($sformatf("s_cfg%0d_v%0d", ci, v), {61'd0, s_pt}, {61'd0, ref_pt(s_cfg[ci], s_uim, s_flb)});
      end
      $display("sweep config %0d done", ci);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
